// File: rtl/eth_pattern_checker.sv
// eth_pattern_checker
// Sits behind the Ethernet header parser. Filters frames on destination MAC
// and ethertype, checks that accepted payloads carry an incrementing byte
// pattern (00,01,..,FF,00,..) of exactly LENGTH bytes, and reports
// per-frame good/bad pulses plus saturating statistics for debug readout.
module eth_pattern_checker #(
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_00,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter logic [15:0] ETH_TYPE     = 16'h88B5,
    parameter int unsigned LENGTH       = 512,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_eth_hdr_valid,
    output logic                 s_eth_hdr_ready,
    input  logic [47:0]          s_eth_dest_mac,
    input  logic [47:0]          s_eth_src_mac,
    input  logic [15:0]          s_eth_type,
    input  logic [7:0]           s_eth_payload_axis_tdata,
    input  logic                 s_eth_payload_axis_tvalid,
    output logic                 s_eth_payload_axis_tready,
    input  logic                 s_eth_payload_axis_tlast,
    input  logic                 s_eth_payload_axis_tuser,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [CNT_WIDTH-1:0] good_count,
    output logic [CNT_WIDTH-1:0] bad_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 seq_err_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    // Index of each statistics counter inside cnt_inc.
    localparam int CNT_GOOD = 0;
    localparam int CNT_BAD  = 1;
    localparam int CNT_DROP = 2;

    // Compared against byte_cnt+1 in 17 bits so a saturated count can never
    // alias onto a legal length.
    localparam logic [16:0] LENGTH_C = 17'(LENGTH);

    state_t      state_q, state_d;
    logic [7:0]  exp_byte_q, exp_byte_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;
    logic        frame_good_q, frame_good_d;
    logic        frame_bad_q, frame_bad_d;
    logic [2:0]  cnt_inc;

    logic        hdr_fire;
    logic        beat;
    logic        dest_match;
    logic        hdr_match;
    logic        byte_ok;
    logic        pass;
    logic [16:0] byte_cnt_plus1;

    // Source MAC is carried by the parser interface but plays no part here.
    logic        unused_src_mac;
    assign unused_src_mac = ^s_eth_src_mac;

    // Ready signals are a function of state only.
    assign s_eth_hdr_ready           = (state_q == ST_IDLE);
    assign s_eth_payload_axis_tready = (state_q != ST_IDLE);

    assign hdr_fire   = s_eth_hdr_valid && s_eth_hdr_ready;
    assign beat       = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign dest_match = (s_eth_dest_mac == LOCAL_MAC) ||
                        (ACCEPT_BCAST && (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF));
    assign hdr_match  = dest_match && (s_eth_type == ETH_TYPE);
    assign byte_ok    = (s_eth_payload_axis_tdata == exp_byte_q);
    assign byte_cnt_plus1 = {1'b0, byte_cnt_q} + 17'd1;
    assign pass       = !err_q && byte_ok && !s_eth_payload_axis_tuser &&
                        (byte_cnt_plus1 == LENGTH_C);

    // Next-state, per-frame checking and pulse generation.
    always_comb begin
        state_d      = state_q;
        exp_byte_d   = exp_byte_q;
        byte_cnt_d   = byte_cnt_q;
        err_d        = err_q;
        sticky_d     = sticky_q;
        frame_good_d = 1'b0;
        frame_bad_d  = 1'b0;
        cnt_inc      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    exp_byte_d = 8'd0;
                    byte_cnt_d = 16'd0;
                    err_d      = 1'b0;
                    state_d    = hdr_match ? ST_CHECK : ST_DROP;
                end
            end
            ST_CHECK: begin
                if (beat) begin
                    if (!byte_ok) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                    exp_byte_d = exp_byte_q + 8'd1;
                    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    if (s_eth_payload_axis_tlast) begin
                        frame_good_d      = pass;
                        frame_bad_d       = !pass;
                        cnt_inc[CNT_GOOD] = pass;
                        cnt_inc[CNT_BAD]  = !pass;
                        state_d           = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_eth_payload_axis_tlast) begin
                    cnt_inc[CNT_DROP] = 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and per-frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            exp_byte_q   <= 8'd0;
            byte_cnt_q   <= 16'd0;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_byte_q   <= exp_byte_d;
            byte_cnt_q   <= byte_cnt_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
            frame_good_q <= frame_good_d;
            frame_bad_q  <= frame_bad_d;
        end
    end

    // One saturating statistics counter per event type.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

            // Increment on the event unless already at all-ones.
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end

            // Counter register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign good_count     = g_cnt[CNT_GOOD].cnt_q;
    assign bad_count      = g_cnt[CNT_BAD].cnt_q;
    assign drop_count     = g_cnt[CNT_DROP].cnt_q;
    assign frame_good     = frame_good_q;
    assign frame_bad      = frame_bad_q;
    assign seq_err_sticky = sticky_q;

endmodule
